ntt_schedule_ctrl: RTL and testbench

//  Parametrised successor to the fixed fsm/address_generator pair: schedules a full in-place NTT, INTT
//  or pointwise pass over N=2^N_LOG coefficients for NBF parallel butterflies.

---
 rtl/ntt_schedule_ctrl_pkg.sv | 30 +++
 rtl/ntt_schedule_ctrl_addr_delay.sv | 43 ++++
 rtl/ntt_schedule_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ntt_schedule_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_schedule_ctrl_pkg.sv
// Shared types and helpers for the NTT pass scheduler.
// Mode and FSM encodings plus a constant-friendly clog2.
package ntt_schedule_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_NTT  = 2'd0,
        MODE_INTT = 2'd1,
        MODE_PWM  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_schedule_ctrl_addr_delay.sv
// Valid+data shift register matching the butterfly pipeline latency.
// A flush drops every in-flight entry on the next edge.
module ntt_schedule_ctrl_addr_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     dat_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else if (flush_i) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= valid_i;
            dat_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/ntt_schedule_ctrl.sv
// Schedules in-place NTT / INTT / pointwise passes for NBF lanes.
// Issues read and twiddle addresses, and delayed write addresses.
module ntt_schedule_ctrl
    import ntt_schedule_ctrl_pkg::*;
#(
    parameter int N_LOG        = 8,
    parameter int NBF          = 4,
    parameter int PIPE_LAT     = 6,
    parameter int INTT_TF_BASE = 256,
    parameter int PWM_TF_BASE  = 512,
    parameter int TF_W         = 10,
    localparam int SW          = clog2(N_LOG),
    localparam int AW          = 2 * NBF * N_LOG
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        bf_sel_o,
    output logic [SW-1:0]     stage_o,
    output logic              rd_valid_o,
    output logic [AW-1:0]     rd_addr_o,
    output logic              wr_valid_o,
    output logic [AW-1:0]     wr_addr_o,
    output logic [NBF*TF_W-1:0] tf_addr_o
);

    localparam int CPS = (1 << N_LOG) / (2 * NBF);
    localparam int CMX = (CPS > PIPE_LAT) ? CPS : PIPE_LAT;
    localparam int CW  = clog2(CMX) + 1;

    state_e          state_q, state_d;
    mode_e           mode_q, mode_d;
    logic [CW-1:0]   c_q, c_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [SW-1:0]   last;
    logic            flush;

    logic            busy_q, done_q, rd_valid_q;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [NBF*TF_W-1:0] tf_addr_q, tf_addr_d;

    assign last = (mode_q == MODE_PWM) ? '0 : SW'(N_LOG - 1);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        c_d     = c_q;
        stage_d = stage_q;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i && mode_i != MODE_RSVD) begin
                    state_d = S_RUN;
                    mode_d  = mode_e'(mode_i);
                    c_d     = '0;
                    stage_d = '0;
                end
            end
            S_RUN: begin
                if (c_q == CW'(CPS - 1)) begin
                    state_d = S_DRAIN;
                    c_d     = '0;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (c_q == CW'(PIPE_LAT - 1)) begin
                    c_d = '0;
                    if (stage_q == last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                stage_d = '0;
            end
        endcase
        // abort beats any other transition and kills in-flight writes
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            c_d     = '0;
            stage_d = '0;
            flush   = 1'b1;
        end
    end

    // addresses are computed from next-state so they register alongside rd_valid
    always_comb begin
        int jj, st, ld, up, lo, tf;
        rd_addr_d = '0;
        tf_addr_d = '0;
        for (int b = 0; b < NBF; b++) begin
            jj = 32'(c_d) * NBF + b;
            st = 32'(stage_d);
            case (mode_d)
                MODE_NTT:  ld = N_LOG - 1 - st;
                MODE_INTT: ld = st;
                default:   ld = 0;
            endcase
            if (mode_d == MODE_PWM) begin
                up = 2 * jj;
                lo = up + 1;
                tf = PWM_TF_BASE + jj;
            end else begin
                up = ((jj >> ld) << (ld + 1)) | (jj & ((1 << ld) - 1));
                lo = up + (1 << ld);
                if (mode_d == MODE_NTT) begin
                    tf = (1 << st) + (jj >> ld);
                end else begin
                    tf = INTT_TF_BASE + (1 << (N_LOG - 1 - st)) + (jj >> ld);
                end
            end
            rd_addr_d[2*b*N_LOG +: 2*N_LOG] = {N_LOG'(up), N_LOG'(lo)};
            tf_addr_d[b*TF_W +: TF_W]       = TF_W'(tf);
        end
        if (state_d != S_RUN) begin
            rd_addr_d = '0;
            tf_addr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_NTT;
            c_q        <= '0;
            stage_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            tf_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            c_q        <= c_d;
            stage_q    <= stage_d;
            busy_q     <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q     <= (state_d == S_DONE);
            rd_valid_q <= (state_d == S_RUN);
            rd_addr_q  <= rd_addr_d;
            tf_addr_q  <= tf_addr_d;
        end
    end

    ntt_schedule_ctrl_addr_delay #(
        .DEPTH (PIPE_LAT),
        .W     (AW)
    ) u_wr_delay (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush),
        .valid_i (rd_valid_q),
        .data_i  (rd_addr_q),
        .valid_o (wr_valid_o),
        .data_o  (wr_addr_o)
    );

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign bf_sel_o   = mode_q;
    assign stage_o    = stage_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_addr_o  = rd_addr_q;
    assign tf_addr_o  = tf_addr_q;

endmodule

// File: tb/tb_ntt_schedule_ctrl.sv
// Scoreboard bench for the NTT scheduler: default and small INTT configs.
// Expected addresses are queued at start and matched on rd/wr valid.
module tb_ntt_schedule_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, abort_a = 1'b0;
    logic [1:0]  mode_a = 2'd0;
    logic        busy_a, done_a, rv_a, wv_a;
    logic [1:0]  bf_a;
    logic [2:0]  stage_a;
    logic [63:0] ra_a, wa_a;
    logic [39:0] tf_a;

    logic        start_b = 1'b0, abort_b = 1'b0;
    logic [1:0]  mode_b = 2'd0;
    logic        busy_b, done_b, rv_b, wv_b;
    logic [1:0]  bf_b;
    logic [1:0]  stage_b;
    logic [5:0]  ra_b, wa_b;
    logic [9:0]  tf_b;

    ntt_schedule_ctrl u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .mode_i(mode_a),
        .abort_i(abort_a), .busy_o(busy_a), .done_o(done_a), .bf_sel_o(bf_a),
        .stage_o(stage_a), .rd_valid_o(rv_a), .rd_addr_o(ra_a),
        .wr_valid_o(wv_a), .wr_addr_o(wa_a), .tf_addr_o(tf_a)
    );

    ntt_schedule_ctrl #(.N_LOG(3), .NBF(1), .PIPE_LAT(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .mode_i(mode_b),
        .abort_i(abort_b), .busy_o(busy_b), .done_o(done_b), .bf_sel_o(bf_b),
        .stage_o(stage_b), .rd_valid_o(rv_b), .rd_addr_o(ra_b),
        .wr_valid_o(wv_b), .wr_addr_o(wa_b), .tf_addr_o(tf_b)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] tf;
        int          st;
        int          t;
    } rec_t;

    rec_t qrd[$];
    rec_t qwr[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic ab,
                         input logic [1:0] md);
        if (w == 0) begin
            start_a = st; abort_a = ab; mode_a = md;
        end else begin
            start_b = st; abort_b = ab; mode_b = md;
        end
    endtask

    task automatic run(input int w, input int md, input int abort_t,
                       input int poke_t);
        int nl, nbf, lat, cps, per, nst, total;
        int j, d, up, lo, tf;
        logic aborted, e_busy, e_rv, e_done;
        logic busy, done, rv, wv;
        logic [1:0] bf, cur_md;
        logic [63:0] ra, wa, tfv, stg;
        rec_t r;
        nl  = (w != 0) ? 3 : 8;
        nbf = (w != 0) ? 1 : 4;
        lat = (w != 0) ? 2 : 6;
        cps = (1 << nl) / (2 * nbf);
        per = cps + lat;
        nst = (md == 2) ? 1 : nl;
        total = nst * per;
        qrd.delete();
        qwr.delete();
        for (int s = 0; s < nst; s++) begin
            for (int c = 0; c < cps; c++) begin
                r.addr = '0; r.tf = '0; r.st = s; r.t = 0;
                for (int b = 0; b < nbf; b++) begin
                    j = c * nbf + b;
                    if (md == 2) begin
                        up = 2 * j; lo = up + 1; tf = 512 + j;
                    end else begin
                        d  = (md == 0) ? ((1 << nl) >> (s + 1)) : (1 << s);
                        up = (j / d) * 2 * d + (j % d);
                        lo = up + d;
                        if (md == 0) tf = (1 << s) + j / d;
                        else tf = 256 + ((1 << nl) >> (s + 1)) + j / d;
                    end
                    tf = tf & 1023;
                    r.addr = r.addr | (64'(up) << ((2 * b + 1) * nl))
                                    | (64'(lo) << (2 * b * nl));
                    r.tf = r.tf | (64'(tf) << (10 * b));
                end
                qrd.push_back(r);
            end
        end
        cur_md = 2'(md);
        @(negedge clk);
        drive(w, 1'b1, 1'b0, cur_md);
        @(posedge clk); #1;
        aborted = 1'b0;
        for (int t = 1; t <= total + 6; t++) begin
            drive(w, 1'b0, 1'b0, cur_md);
            busy = (w != 0) ? busy_b : busy_a;
            done = (w != 0) ? done_b : done_a;
            rv   = (w != 0) ? rv_b : rv_a;
            wv   = (w != 0) ? wv_b : wv_a;
            bf   = (w != 0) ? bf_b : bf_a;
            ra   = (w != 0) ? {58'b0, ra_b} : ra_a;
            wa   = (w != 0) ? {58'b0, wa_b} : wa_a;
            tfv  = (w != 0) ? {54'b0, tf_b} : {24'b0, tf_a};
            stg  = (w != 0) ? {62'b0, stage_b} : {61'b0, stage_a};
            e_busy = !aborted && (t <= total);
            e_rv   = e_busy && (((t - 1) % per) < cps);
            e_done = !aborted && (t == total + 1);
            chk("busy", 64'(busy), 64'(e_busy));
            chk("rd_valid", 64'(rv), 64'(e_rv));
            chk("done", 64'(done), 64'(e_done));
            chk("bf_sel", 64'(bf), 64'(md));
            if (rv) begin
                if (qrd.size() == 0) begin
                    chk("rd_unexp", 64'(rv), 64'd0);
                end else begin
                    r = qrd.pop_front();
                    chk("rd_addr", ra, r.addr);
                    chk("tf_addr", tfv, r.tf);
                    chk("stage", stg, 64'(r.st));
                    r.t = t;
                    qwr.push_back(r);
                end
            end
            if (wv) begin
                if (qwr.size() == 0) begin
                    chk("wr_unexp", 64'(wv), 64'd0);
                end else begin
                    r = qwr.pop_front();
                    chk("wr_addr", wa, r.addr);
                    chk("wr_lat", 64'(t - r.t), 64'(lat));
                end
            end
            if (t == poke_t) begin
                cur_md = (md == 0) ? 2'd2 : 2'd0;
                drive(w, 1'b1, 1'b0, cur_md);
            end
            if (t == abort_t) begin
                drive(w, 1'b0, 1'b1, cur_md);
                aborted = 1'b1;
                qrd.delete();
                qwr.delete();
            end
            @(posedge clk); #1;
        end
        drive(w, 1'b0, 1'b0, cur_md);
        chk("rd_left", 64'(qrd.size()), 64'd0);
        chk("wr_left", 64'(qwr.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_rv", 64'(rv_a), 64'd0);
        chk("rst_wv", 64'(wv_a), 64'd0);
        chk("rst_stage", 64'(stage_a), 64'd0);
        chk("rst_rd_addr", ra_a, 64'd0);
        chk("rst_wr_addr", wa_a, 64'd0);
        chk("rst_tf", 64'(tf_a), 64'd0);
        chk("rst_busy_b", 64'(busy_b), 64'd0);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run(0, 0, -1, 50);
        run(1, 1, -1, 10);
        run(0, 2, -1, -1);
        run(0, 0, 149, -1);
        run(0, 0, -1, -1);

        @(negedge clk);
        start_a = 1'b1;
        mode_a = 2'd3;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rsvd_busy", 64'(busy_a), 64'd0);
            chk("rsvd_rv", 64'(rv_a), 64'd0);
        end

        @(negedge clk);
        mode_a = 2'd0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_wv_pre", 64'(wv_a), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 64'(busy_a), 64'd0);
        chk("mid_rv", 64'(rv_a), 64'd0);
        chk("mid_wv", 64'(wv_a), 64'd0);
        chk("mid_stage", 64'(stage_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_busy", 64'(busy_a), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
